// File: rtl/amem_pkg.sv
// Shared types and defaults for the A-memory address controller.
// Holds the pending-write entry type, field defaults and pointer helper.
package amem_pkg;

  localparam int AW_MAX      = 16;
  localparam int AW_DEF      = 10;
  localparam int IRW_DEF     = 49;
  localparam int SRC_LSB_DEF = 32;
  localparam int DST_LSB_DEF = 14;
  localparam int DSTM_W_DEF  = 5;
  localparam int DEPTH_DEF   = 2;

  // addr is held zero-extended to AW_MAX so one type serves every AW.
  typedef struct packed {
    logic              valid;
    logic [AW_MAX-1:0] addr;
  } amem_entry_t;

  function automatic logic [2:0] ptr_inc(
    input logic [2:0] p,
    input int         depth
  );
    if (int'(p) == depth - 1) return 3'd0;
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/amem_wq.sv
// Pending A-memory write queue: storage, pointers, occupancy, sticky flags.
// Ports: clk, reset, push, pop, din in; ents, rd_ptr, count, ovf, unf out.
module amem_wq
  import amem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  amem_entry_t din,
  output amem_entry_t ents [DEPTH],
  output logic [2:0]  rd_ptr,
  output logic [3:0]  count,
  output logic        ovf,
  output logic        unf
);

  logic [2:0] wr_ptr;
  logic       do_pop;
  logic       do_push;
  logic       full;
  logic       empty;

  assign empty = (count == 4'd0);
  assign full  = (count == 4'(DEPTH));

  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when a pop frees the head slot.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        ents[j] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (do_push) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (3'(j) == wr_ptr) ents[j] <= din;
        end
        wr_ptr <= ptr_inc(wr_ptr, DEPTH);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr, DEPTH);
      end
      if (do_push && !do_pop) begin
        count <= count + 4'd1;
      end else if (do_pop && !do_push) begin
        count <= count - 4'd1;
      end
      if (push && full && !do_pop) ovf <= 1'b1;
      if (pop && empty) unf <= 1'b1;
    end
  end

endmodule

// File: rtl/amem_addr_ctl.sv
// A-memory address control: source/dest address mux, write queue, bypass.
// Ports: clk, reset, state_decode, state_write, ir, dest, destm in;
// aadr, wadr, arp, awp, byp_hit, byp_sel, count, ovf, unf out.
module amem_addr_ctl
  import amem_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int IRW     = IRW_DEF,
  parameter int SRC_LSB = SRC_LSB_DEF,
  parameter int DST_LSB = DST_LSB_DEF,
  parameter int DSTM_W  = DSTM_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           state_decode,
  input  logic           state_write,
  input  logic [IRW-1:0] ir,
  input  logic           dest,
  input  logic           destm,
  output logic [AW-1:0]  aadr,
  output logic [AW-1:0]  wadr,
  output logic           arp,
  output logic           awp,
  output logic           byp_hit,
  output logic [2:0]     byp_sel,
  output logic [3:0]     count,
  output logic           ovf,
  output logic           unf
);

  logic [AW-1:0]     src;
  logic [AW-1:0]     dst_full;
  logic [DSTM_W-1:0] dst_short;
  logic [AW_MAX-1:0] src_ext;
  amem_entry_t       din;
  amem_entry_t       head;
  amem_entry_t       ents [DEPTH];
  logic [2:0]        rd_ptr;
  logic              unused_ir;
  logic              unused_head;

  assign src       = ir[SRC_LSB +: AW];
  assign dst_full  = ir[DST_LSB +: AW];
  assign dst_short = ir[DST_LSB +: DSTM_W];
  assign src_ext   = AW_MAX'(src);
  assign unused_ir = ^ir;

  always_comb begin
    din       = '0;
    din.valid = dest;
    din.addr  = destm ? AW_MAX'(dst_short)
                      : AW_MAX'(dst_full);
  end

  amem_wq #(
    .DEPTH (DEPTH)
  ) u_wq (
    .clk    (clk),
    .reset  (reset),
    .push   (state_decode),
    .pop    (state_write),
    .din    (din),
    .ents   (ents),
    .rd_ptr (rd_ptr),
    .count  (count),
    .ovf    (ovf),
    .unf    (unf)
  );

  always_comb begin
    head = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (3'(j) == rd_ptr) head = ents[j];
    end
  end

  assign unused_head = ^head.addr;

  assign wadr = (count != 4'd0) ? head.addr[AW-1:0] : '0;
  assign awp  = state_write & (count != 4'd0) & head.valid;
  assign arp  = state_decode;
  assign aadr = state_write ? wadr : src;

  // Walk ages oldest to youngest so the last match wins.
  always_comb begin
    logic [3:0]  slot;
    amem_entry_t e;
    byp_hit = 1'b0;
    byp_sel = 3'd0;
    slot    = '0;
    e       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = {1'b0, rd_ptr} + 4'(i);
      if (slot >= 4'(DEPTH)) slot = slot - 4'(DEPTH);
      e = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (4'(j) == slot) e = ents[j];
      end
      if ((4'(i) < count) && e.valid && (e.addr == src_ext)) begin
        byp_hit = 1'b1;
        byp_sel = 3'(i);
      end
    end
  end

endmodule
